result_writeback: RTL and testbench
===================================

# result_writeback

Output-side companion to the img2col tensor/weight address generators. It accepts the GEMM result stream produced from those addresses and writes each result into output-feature-map memory in channel-major layout. It computes the output plane geometry from the same convolution configuration, using iterative (divider-free, multiplier-free) arithmetic. It sits between the GEMM accumulator output and the output SRAM write port, and reports completion and configuration errors to the controller.

## Interface
- TENSOR_SIZE, 8: width of tensor_size (square input edge)
- KERNEL_SIZE, 4: width of kernel_size
- STRIDE_SIZE, 4: width of stride
- KERNEL_NUMS_SIZE, 8: width of kernel_nums
- ADDR_SIZE, 16: output memory address width
- DATA_WIDTH, 32: result word width

Ports:
- clk  in  1  clock; one clock domain; all state on the rising edge
- rstn  in  1  asynchronous, active-low reset
- enable  in  1  level; rising-edge start in IDLE; low aborts any run
- tensor_size  in  TENSOR_SIZE  input edge length; sampled at start
- kernel_size  in  KERNEL_SIZE  kernel edge; sampled at start
- stride  in  STRIDE_SIZE  convolution stride; sampled at start
- kernel_nums  in  KERNEL_NUMS_SIZE  output channel count; sampled at start
- in_valid  in  1  result beat valid
- in_data  in  DATA_WIDTH  result beat
- in_ready  out  1  high only in RUN
- o_wr_en  out  1  output memory write strobe (registered)
- o_wr_addr  out  ADDR_SIZE  write address (registered)
- o_wr_data  out  DATA_WIDTH  write data (registered)
- o_done  out  1  level; high in DONE
- o_cfg_err  out  1  level; high in DONE when the configuration was illegal

## Operation
- States: IDLE, DIV, MUL, RUN, DONE.
- IDLE: on enable 0→1, latch the configuration.
  - Illegal configuration (stride==0 or kernel_size>tensor_size): go to DONE with o_cfg_err=1.
  - Otherwise set rem=tensor_size-kernel_size and q=0, then go to DIV.
- DIV: each cycle, if rem>=stride, then rem-=stride and q++. Otherwise out_dim=q+1, plane=0, cnt=0, and go to MUL.
- MUL: each cycle, plane+=out_dim and cnt++. When cnt reaches out_dim-1 (the out_dim-th add), go to RUN.
  - If kernel_nums==0, go to DONE instead, with no writes and o_cfg_err=0.
- RUN: a beat is accepted when in_valid && in_ready.
  - Stream order: pixel outer (row-major, plane entries), kernel index k inner (0..kernel_nums-1).
  - Address = k*plane + p, kept incrementally:
    - k_off advances by plane per beat.
    - On k wrap, k_off resets to 0 and p increments.
  - Arithmetic is modulo 2^ADDR_SIZE.
- The accepted beat is registered to o_wr_en/o_wr_addr/o_wr_data on the next cycle. There is no write backpressure; memory always accepts.
- After the beat with p=plane-1 and k=kernel_nums-1, go to DONE.
- DONE: o_done=1 and in_ready=0. Remain until enable=0, then return to IDLE.
- enable low in DIV/MUL/RUN: go to IDLE next cycle; drop counters; no further writes.
  - A write registered in that same edge still appears once.
- in_valid outside RUN is ignored and never written.
- Configuration changes after start have no effect until the next start.

## Timing
- Reset values: in_ready=0, o_wr_en=0, o_wr_addr=0, o_wr_data=0, o_done=0, o_cfg_err=0. State is IDLE and all counters are 0.
- Reset mid-run takes effect immediately: no write strobe is produced after reset assertion.
- Start to RUN latency: 1 (IDLE→DIV) + (floor((tensor_size-kernel_size)/stride)+1) DIV cycles + out_dim MUL cycles.
- in_ready rises on the first RUN cycle.
- Write latency is one cycle: a beat accepted at edge t gives o_wr_en=1 after edge t, for exactly one cycle per beat.
- Back-to-back beats give continuous o_wr_en.
- o_done rises together with the o_wr_en of the final write.
- o_cfg_err is valid whenever o_done=1. Both clear on return to IDLE.
- A start requires enable 0→1 observed in IDLE. enable held high after DONE does not restart.

## Test plan
- tensor 5, kernel 3, stride 1, kernel_nums 2, continuous valid:
  - out_dim=3, plane=9; 18 writes.
  - Addresses 0,9,1,10,…,8,17; data echoes input.
  - in_ready rises 1+3+3 cycles after the enable edge; o_done rises with the final write.
- tensor 7, kernel 3, stride 2, kernel_nums 1, in_valid toggling every other cycle:
  - out_dim=3; addresses 0..8 in order.
  - No write on idle-valid cycles.
- stride 0, then separately kernel 5 with tensor 3:
  - DONE with o_cfg_err=1; no writes; in_ready never high.
- kernel_nums 0:
  - DONE with o_cfg_err=0; zero writes.
- enable dropped after the 4th accepted beat:
  - Exactly 4 writes; IDLE next cycle.
  - A restart produces addresses starting at 0.
- rstn asserted mid-RUN:
  - All outputs 0 immediately.
  - A later start behaves identically to the first scenario.

Source files
------------

// File: rtl/result_writeback.sv
// ---------------------------------------------------------------------------
// result_writeback
//
// Accepts the GEMM result stream produced from the img2col addresses and
// writes each result into output-feature-map memory in channel-major layout
// (address = k*plane + p). The output plane geometry is derived from the
// convolution configuration with iterative subtract/add arithmetic, so no
// divider or multiplier is needed.
//
// Ports
//   clk          rising-edge clock
//   rstn         asynchronous active-low reset
//   enable       level; a 0->1 edge in IDLE starts a run, low aborts a run
//   tensor_size  input edge length            (sampled at start)
//   kernel_size  kernel edge length           (sampled at start)
//   stride       convolution stride           (sampled at start)
//   kernel_nums  output channel count         (sampled at start)
//   in_valid     result beat valid
//   in_data      result beat
//   in_ready     high while streaming results (RUN and enable)
//   o_wr_en      registered output-memory write strobe
//   o_wr_addr    registered write address
//   o_wr_data    registered write data
//   o_done       high in DONE
//   o_cfg_err    high in DONE when the configuration was illegal
// ---------------------------------------------------------------------------
module result_writeback #(
    parameter int TENSOR_SIZE      = 8,
    parameter int KERNEL_SIZE      = 4,
    parameter int STRIDE_SIZE      = 4,
    parameter int KERNEL_NUMS_SIZE = 8,
    parameter int ADDR_SIZE        = 16,
    parameter int DATA_WIDTH       = 32
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        enable,
    input  logic [TENSOR_SIZE-1:0]      tensor_size,
    input  logic [KERNEL_SIZE-1:0]      kernel_size,
    input  logic [STRIDE_SIZE-1:0]      stride,
    input  logic [KERNEL_NUMS_SIZE-1:0] kernel_nums,
    input  logic                        in_valid,
    input  logic [DATA_WIDTH-1:0]       in_data,
    output logic                        in_ready,
    output logic                        o_wr_en,
    output logic [ADDR_SIZE-1:0]        o_wr_addr,
    output logic [DATA_WIDTH-1:0]       o_wr_data,
    output logic                        o_done,
    output logic                        o_cfg_err
);

    // out_dim can reach 2^TENSOR_SIZE (e.g. kernel 0, stride 1), so it
    // needs one extra bit over the tensor edge.
    localparam int OD_W = TENSOR_SIZE + 1;

    typedef enum logic [2:0] {IDLE, DIV, MUL, RUN, DONE} state_t;

    state_t                      state, state_next;
    logic                        enable_d;
    logic [TENSOR_SIZE-1:0]      stride_q;
    logic [KERNEL_NUMS_SIZE-1:0] kn_q;
    logic                        cfg_err_q;
    logic [TENSOR_SIZE-1:0]      rem, q;
    logic [OD_W-1:0]             out_dim, cnt;
    logic [ADDR_SIZE-1:0]        plane, p, k_off;
    logic [KERNEL_NUMS_SIZE-1:0] k;

    logic [TENSOR_SIZE-1:0] kernel_ext, stride_ext;
    logic start, illegal, accept, div_done, mul_done, beat_last, abort;

    assign kernel_ext = {{(TENSOR_SIZE-KERNEL_SIZE){1'b0}}, kernel_size};
    assign stride_ext = {{(TENSOR_SIZE-STRIDE_SIZE){1'b0}}, stride};

    assign start     = (state == IDLE) && enable && !enable_d;
    assign illegal   = (stride == '0) || (kernel_ext > tensor_size);
    assign in_ready  = (state == RUN) && enable;
    assign accept    = in_valid && in_ready;
    assign div_done  = (rem < stride_q);
    assign mul_done  = (cnt == out_dim - OD_W'(1));
    assign beat_last = accept && (k == kn_q - KERNEL_NUMS_SIZE'(1))
                              && (p == plane - ADDR_SIZE'(1));
    assign abort     = !enable && ((state == DIV) || (state == MUL) || (state == RUN));

    assign o_done    = (state == DONE);
    assign o_cfg_err = (state == DONE) && cfg_err_q;

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            enable_d <= 1'b0;
        end else begin
            state    <= state_next;
            enable_d <= enable;
        end
    end

    // NOTE: state_next gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = illegal ? DONE : DIV;
            DIV: begin
                if (!enable)       state_next = IDLE;
                else if (div_done) state_next = MUL;
            end
            MUL: begin
                if (!enable)       state_next = IDLE;
                else if (mul_done) state_next = (kn_q == '0) ? DONE : RUN;
            end
            RUN: begin
                if (!enable)        state_next = IDLE;
                else if (beat_last) state_next = DONE;
            end
            DONE: if (!enable) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Geometry and address counters. Everything is dropped in IDLE and on an
    // abort, so a restart always begins from address 0.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stride_q  <= '0;
            kn_q      <= '0;
            cfg_err_q <= 1'b0;
            rem       <= '0;
            q         <= '0;
            out_dim   <= '0;
            cnt       <= '0;
            plane     <= '0;
            p         <= '0;
            k         <= '0;
            k_off     <= '0;
        end else if ((state == IDLE) || abort) begin
            rem     <= '0;
            q       <= '0;
            out_dim <= '0;
            cnt     <= '0;
            plane   <= '0;
            p       <= '0;
            k       <= '0;
            k_off   <= '0;
            if (start) begin
                stride_q  <= stride_ext;
                kn_q      <= kernel_nums;
                cfg_err_q <= illegal;
                rem       <= tensor_size - kernel_ext;
            end
        end else begin
            case (state)
                DIV: begin
                    if (!div_done) begin
                        rem <= rem - stride_q;
                        q   <= q + TENSOR_SIZE'(1);
                    end else begin
                        out_dim <= OD_W'(q) + OD_W'(1);
                        plane   <= '0;
                        cnt     <= '0;
                    end
                end
                MUL: begin
                    // plane = out_dim * out_dim by repeated addition
                    plane <= plane + ADDR_SIZE'(out_dim);
                    cnt   <= cnt + OD_W'(1);
                end
                RUN: begin
                    if (accept) begin
                        // kernel index is the inner loop: stepping k moves by
                        // a whole plane; wrapping k moves to the next pixel
                        if (k == kn_q - KERNEL_NUMS_SIZE'(1)) begin
                            k     <= '0;
                            k_off <= '0;
                            p     <= p + ADDR_SIZE'(1);
                        end else begin
                            k     <= k + KERNEL_NUMS_SIZE'(1);
                            k_off <= k_off + plane;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Write port: accepted beat appears exactly one cycle later.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            o_wr_en   <= 1'b0;
            o_wr_addr <= '0;
            o_wr_data <= '0;
        end else begin
            o_wr_en <= accept;
            if (accept) begin
                o_wr_addr <= k_off + p;
                o_wr_data <= in_data;
            end
        end
    end

endmodule

// File: tb/tb_result_writeback.sv
// ---------------------------------------------------------------------------
// tb_result_writeback
//
// Directed bench for result_writeback: nominal stream, toggling valid,
// illegal configurations, zero kernels, enable abort with restart, and
// reset mid-run followed by a repeat of the nominal run.
// ---------------------------------------------------------------------------
module tb_result_writeback;

    logic        clk;
    logic        rstn;
    logic        enable;
    logic [7:0]  tensor_size;
    logic [3:0]  kernel_size;
    logic [3:0]  stride;
    logic [7:0]  kernel_nums;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        o_wr_en;
    logic [15:0] o_wr_addr;
    logic [31:0] o_wr_data;
    logic        o_done;
    logic        o_cfg_err;

    int n_cmp = 0;
    int n_err = 0;
    int wr_seen = 0;

    result_writeback dut (
        .clk         (clk),
        .rstn        (rstn),
        .enable      (enable),
        .tensor_size (tensor_size),
        .kernel_size (kernel_size),
        .stride      (stride),
        .kernel_nums (kernel_nums),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .o_wr_en     (o_wr_en),
        .o_wr_addr   (o_wr_addr),
        .o_wr_data   (o_wr_data),
        .o_done      (o_done),
        .o_cfg_err   (o_cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] observed,
                         input logic [63:0] expected);
        n_cmp++;
        assert (observed === expected)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next falling edge and log any write strobe.
    task automatic tick();
        @(negedge clk);
        #1;
        if (rstn && o_wr_en) wr_seen++;
    endtask

    // Wait (bounded) for in_ready; returns the number of cycles it took.
    task automatic wait_ready(input string tag, output int lat);
        lat = 0;
        while (!in_ready && lat < 100) begin
            tick();
            lat++;
        end
        check(tag, 64'(in_ready), 64'd1);
    endtask

    task automatic set_cfg(input int ts, input int ks, input int st, input int kn);
        tensor_size = 8'(ts);
        kernel_size = 4'(ks);
        stride      = 4'(st);
        kernel_nums = 8'(kn);
    endtask

    // tensor 5, kernel 3, stride 1, 2 kernels: out_dim 3, plane 9, 18 writes.
    task automatic run_basic(input string tag);
        int lat;
        set_cfg(5, 3, 1, 2);
        in_valid = 1'b0;
        enable   = 1'b1;
        wait_ready({tag, "_ready"}, lat);
        check({tag, "_latency"}, 64'(lat), 64'd7);
        for (int i = 0; i < 18; i++) begin
            in_valid = 1'b1;
            in_data  = 32'hA000_0000 + 32'(i);
            tick();
            check({tag, "_wr_en"}, 64'(o_wr_en), 64'd1);
            check({tag, "_addr"}, 64'(o_wr_addr), 64'((i % 2) * 9 + i / 2));
            check({tag, "_data"}, 64'(o_wr_data), 64'(32'hA000_0000 + 32'(i)));
            if (i >= 16) check({tag, "_done_edge"}, 64'(o_done), (i == 17) ? 64'd1 : 64'd0);
        end
        in_valid = 1'b0;
        tick();
        check({tag, "_post_wr_en"}, 64'(o_wr_en), 64'd0);
        check({tag, "_post_done"}, 64'(o_done), 64'd1);
        check({tag, "_post_cfg_err"}, 64'(o_cfg_err), 64'd0);
        check({tag, "_post_ready"}, 64'(in_ready), 64'd0);
        // enable still high: must stay in DONE, no restart
        repeat (3) tick();
        check({tag, "_hold_done"}, 64'(o_done), 64'd1);
        check({tag, "_hold_ready"}, 64'(in_ready), 64'd0);
        enable = 1'b0;
        tick();
        check({tag, "_idle_done"}, 64'(o_done), 64'd0);
        check({tag, "_idle_cfg_err"}, 64'(o_cfg_err), 64'd0);
    endtask

    // Illegal configuration: straight to DONE with the error flag.
    task automatic run_illegal(input string tag, input int ts, input int ks, input int st);
        int w0;
        set_cfg(ts, ks, st, 2);
        w0       = wr_seen;
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
        enable   = 1'b1;
        tick();
        check({tag, "_done"}, 64'(o_done), 64'd1);
        check({tag, "_cfg_err"}, 64'(o_cfg_err), 64'd1);
        check({tag, "_ready"}, 64'(in_ready), 64'd0);
        repeat (3) tick();
        check({tag, "_ready_hold"}, 64'(in_ready), 64'd0);
        check({tag, "_no_writes"}, 64'(wr_seen - w0), 64'd0);
        enable   = 1'b0;
        in_valid = 1'b0;
        tick();
        check({tag, "_idle_done"}, 64'(o_done), 64'd0);
        check({tag, "_idle_cfg_err"}, 64'(o_cfg_err), 64'd0);
    endtask

    initial begin
        int lat;
        int w0;
        int n;
        logic ready_seen;

        rstn     = 1'b0;
        enable   = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        set_cfg(0, 0, 0, 0);
        #1;
        // Reset state
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_wr_en", 64'(o_wr_en), 64'd0);
        check("rst_wr_addr", 64'(o_wr_addr), 64'd0);
        check("rst_wr_data", 64'(o_wr_data), 64'd0);
        check("rst_done", 64'(o_done), 64'd0);
        check("rst_cfg_err", 64'(o_cfg_err), 64'd0);
        repeat (2) tick();
        rstn = 1'b1;
        repeat (2) tick();

        // 1: nominal stream
        run_basic("basic");

        // 2: tensor 7, kernel 3, stride 2, 1 kernel, valid every other cycle
        set_cfg(7, 3, 2, 1);
        enable = 1'b1;
        wait_ready("tog_ready", lat);
        check("tog_latency", 64'(lat), 64'd7);
        for (int c = 0; c < 18; c++) begin
            in_valid = (c % 2 == 0);
            in_data  = 32'h0000_5000 + 32'(c / 2);
            tick();
            if (c % 2 == 0) begin
                check("tog_wr_en", 64'(o_wr_en), 64'd1);
                check("tog_addr", 64'(o_wr_addr), 64'(c / 2));
                check("tog_data", 64'(o_wr_data), 64'(32'h0000_5000 + 32'(c / 2)));
            end else begin
                check("tog_idle_wr_en", 64'(o_wr_en), 64'd0);
            end
            if (c == 16) check("tog_done", 64'(o_done), 64'd1);
        end
        enable   = 1'b0;
        in_valid = 1'b0;
        tick();
        check("tog_idle_done", 64'(o_done), 64'd0);

        // 3: illegal configurations
        run_illegal("stride0", 5, 3, 0);
        run_illegal("kbig", 3, 5, 1);

        // 4: zero kernels
        set_cfg(5, 3, 1, 0);
        w0         = wr_seen;
        ready_seen = 1'b0;
        in_valid   = 1'b1;
        enable     = 1'b1;
        n          = 0;
        while (!o_done && n < 50) begin
            tick();
            ready_seen |= in_ready;
            n++;
        end
        check("kn0_done", 64'(o_done), 64'd1);
        check("kn0_latency", 64'(n), 64'd7);
        check("kn0_cfg_err", 64'(o_cfg_err), 64'd0);
        check("kn0_ready_seen", 64'(ready_seen), 64'd0);
        check("kn0_no_writes", 64'(wr_seen - w0), 64'd0);
        enable   = 1'b0;
        in_valid = 1'b0;
        tick();

        // 5: enable dropped after the 4th accepted beat
        set_cfg(5, 3, 1, 2);
        enable = 1'b1;
        wait_ready("abort_ready", lat);
        w0 = wr_seen;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 32'hB000_0000 + 32'(i);
            tick();
            check("abort_addr", 64'(o_wr_addr), 64'((i % 2) * 9 + i / 2));
        end
        enable = 1'b0;
        tick();
        check("abort_wr_en", 64'(o_wr_en), 64'd0);
        check("abort_ready_low", 64'(in_ready), 64'd0);
        check("abort_done_low", 64'(o_done), 64'd0);
        repeat (3) tick();
        check("abort_write_count", 64'(wr_seen - w0), 64'd4);
        in_valid = 1'b0;
        enable   = 1'b1;
        wait_ready("restart_ready", lat);
        check("restart_latency", 64'(lat), 64'd7);
        in_valid = 1'b1;
        in_data  = 32'hC000_0000;
        tick();
        check("restart_wr_en", 64'(o_wr_en), 64'd1);
        check("restart_addr", 64'(o_wr_addr), 64'd0);
        enable   = 1'b0;
        in_valid = 1'b0;
        tick();

        // 6: reset asserted mid-run
        set_cfg(5, 3, 1, 2);
        enable = 1'b1;
        wait_ready("rst_run_ready", lat);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 32'hD000_0000 + 32'(i);
            tick();
        end
        check("rst_run_wr_en_before", 64'(o_wr_en), 64'd1);
        rstn = 1'b0;
        #1;
        check("rst_run_in_ready", 64'(in_ready), 64'd0);
        check("rst_run_wr_en", 64'(o_wr_en), 64'd0);
        check("rst_run_wr_addr", 64'(o_wr_addr), 64'd0);
        check("rst_run_wr_data", 64'(o_wr_data), 64'd0);
        check("rst_run_done", 64'(o_done), 64'd0);
        check("rst_run_cfg_err", 64'(o_cfg_err), 64'd0);
        w0 = wr_seen;
        repeat (2) tick();
        enable   = 1'b0;
        in_valid = 1'b0;
        tick();
        rstn = 1'b1;
        repeat (2) tick();
        check("rst_run_no_writes", 64'(wr_seen - w0), 64'd0);
        run_basic("after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
